// File: rtl/sha_padder_pkg.sv
// Shared codec constants, sha_type encodings and block geometry for the SHA padder.
// The codec sits in the low nibble of the AXIS tuser sideband.
package sha_padder_pkg;

  localparam logic [3:0] CODEC_SHA1   = 4'h1;
  localparam logic [3:0] CODEC_SHA224 = 4'h2;
  localparam logic [3:0] CODEC_SHA256 = 4'h3;
  localparam logic [3:0] CODEC_SHA384 = 4'h4;
  localparam logic [3:0] CODEC_SHA512 = 4'h5;

  // Bit 1 of sha_type selects the 128-byte block / 128-bit length format.
  typedef enum logic [1:0] {
    SHA_T_160 = 2'b00,
    SHA_T_256 = 2'b01,
    SHA_T_384 = 2'b10,
    SHA_T_512 = 2'b11
  } sha_type_e;

  localparam int BLK64_BYTES  = 64;
  localparam int BLK128_BYTES = 128;
  localparam int LEN64_BYTES  = 8;
  localparam int LEN128_BYTES = 16;
  localparam int BUF_BYTES    = 128;
  localparam int CNT_W        = 61;

  typedef logic [BUF_BYTES-1:0][7:0] blk_t;

  function automatic logic [3:0] extract_codec(input logic [127:0] tuser);
    return tuser[3:0];
  endfunction

  // SHA-224 shares the SHA-256 block format; unknown codecs fall back to it too.
  function automatic sha_type_e codec2sha_type(input logic [3:0] codec);
    case (codec)
      CODEC_SHA1:   return SHA_T_160;
      CODEC_SHA224: return SHA_T_256;
      CODEC_SHA256: return SHA_T_256;
      CODEC_SHA384: return SHA_T_384;
      CODEC_SHA512: return SHA_T_512;
      default:      return SHA_T_256;
    endcase
  endfunction

endpackage

// File: rtl/sha_padder_len_insert.sv
// Combinational pad stage: drops 0x80 at pos, zeroes everything after it,
// and writes the big-endian bit length into the tail of the block.
module sha_padder_len_insert
  import sha_padder_pkg::*;
(
  input  blk_t             blk_i,
  input  logic [7:0]       pos_i,
  input  logic             put80_i,
  input  logic             len_en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             mode128_i,
  output blk_t             blk_o
);

  logic [63:0] len_bits;
  assign len_bits = {cnt_i, 3'b000};

  always_comb begin
    blk_o = blk_i;
    if (put80_i) begin
      for (int j = 0; j < BUF_BYTES; j++) begin
        if (8'(j) > pos_i) blk_o[j] = 8'h00;
      end
      blk_o[pos_i[6:0]] = 8'h80;
    end
    if (len_en_i) begin
      for (int i = 0; i < 8; i++) begin
        if (mode128_i) begin
          blk_o[BLK128_BYTES-1-i] = len_bits[8*i +: 8];
          blk_o[BLK128_BYTES-9-i] = 8'h00;
        end else begin
          blk_o[BLK64_BYTES-1-i] = len_bits[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/sha_padder.sv
// SHA message padder: packs an AXIS byte stream into 64/128-byte blocks,
// appends 0x80 + length, and emits each block as one or two 512-bit beats.
module sha_padder
  import sha_padder_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  localparam int S_BYTES = C_S_AXIS_DATA_WIDTH / 8;
  localparam int NB_W    = $clog2(S_BYTES + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_EMIT_LO = 3'd2;
  localparam logic [2:0] ST_EMIT_HI = 3'd3;
  localparam logic [2:0] ST_PAD     = 3'd4;

  logic [2:0]                    state_q, state_d;
  blk_t                          buf_q, buf_d;
  logic [7:0]                    ptr_q, ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                          mode_q, mode_d;
  logic                          final_q, final_d;
  logic                          pend_q, pend_d;
  logic                          defer_q, defer_d;
  logic                          init_q;

  logic             first, cur_mode, accept, len_fit, blk_full;
  logic [1:0]       cur_type;
  logic [7:0]       base_ptr, new_ptr;
  logic [CNT_W-1:0] base_cnt, new_cnt;
  logic [NB_W-1:0]  nbytes;
  logic [8:0]       blk_bytes, len_bytes;
  blk_t             wr_buf, ins_blk_in, ins_blk;
  logic [7:0]       ins_pos;
  logic             ins_put80, ins_len_en;
  logic [CNT_W-1:0] ins_cnt;

  assign s_axis_tready = init_q && (state_q == ST_IDLE || state_q == ST_FILL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state_q == ST_EMIT_LO) || (state_q == ST_EMIT_HI);
  assign m_axis_tlast  = final_q && ((state_q == ST_EMIT_HI) || (state_q == ST_EMIT_LO && !mode_q));
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdata  = (state_q == ST_EMIT_HI) ? C_M_AXIS_DATA_WIDTH'(buf_q[127:64])
                                                 : C_M_AXIS_DATA_WIDTH'(buf_q[63:0]);

  // Beat merge: a message's first beat starts from a clean buffer and counters.
  always_comb begin
    first    = (state_q == ST_IDLE);
    cur_type = codec2sha_type(extract_codec(s_axis_tuser));
    cur_mode = first ? cur_type[1] : mode_q;
    base_ptr = first ? '0 : ptr_q;
    base_cnt = first ? '0 : cnt_q;
    wr_buf   = first ? '0 : buf_q;
    nbytes   = '0;
    for (int k = 0; k < S_BYTES; k++) begin
      if (s_axis_tkeep[k]) begin
        wr_buf[base_ptr[6:0] + 7'(k)] = s_axis_tdata[8*k +: 8];
        nbytes = nbytes + NB_W'(1);
      end
    end
    new_ptr   = base_ptr + 8'(nbytes);
    new_cnt   = base_cnt + CNT_W'(nbytes);
    blk_bytes = cur_mode ? 9'(BLK128_BYTES) : 9'(BLK64_BYTES);
    len_bytes = cur_mode ? 9'(LEN128_BYTES) : 9'(LEN64_BYTES);
    len_fit   = ({1'b0, new_ptr} + 9'd1) <= (blk_bytes - len_bytes);
    blk_full  = ({1'b0, new_ptr} == blk_bytes);
    if (state_q == ST_PAD) begin
      ins_blk_in = '0;
      ins_pos    = '0;
      ins_put80  = defer_q;
      ins_len_en = 1'b1;
      ins_cnt    = cnt_q;
    end else begin
      ins_blk_in = wr_buf;
      ins_pos    = new_ptr;
      ins_put80  = !blk_full;
      ins_len_en = len_fit;
      ins_cnt    = new_cnt;
    end
  end

  sha_padder_len_insert u_len_insert (
    .blk_i     (ins_blk_in),
    .pos_i     (ins_pos),
    .put80_i   (ins_put80),
    .len_en_i  (ins_len_en),
    .cnt_i     (ins_cnt),
    .mode128_i (cur_mode),
    .blk_o     (ins_blk)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tuser_d = tuser_q;
    mode_d  = mode_q;
    final_d = final_q;
    pend_d  = pend_q;
    defer_d = defer_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          if (first) begin
            tuser_d = s_axis_tuser;
            mode_d  = cur_mode;
            final_d = 1'b0;
            pend_d  = 1'b0;
            defer_d = 1'b0;
          end
          ptr_d = new_ptr;
          cnt_d = new_cnt;
          if (s_axis_tlast) begin
            buf_d   = ins_blk;
            final_d = len_fit;
            pend_d  = !len_fit;
            defer_d = blk_full;
            state_d = ST_EMIT_LO;
          end else begin
            buf_d   = wr_buf;
            state_d = blk_full ? ST_EMIT_LO : ST_FILL;
          end
        end
      end
      ST_EMIT_LO, ST_EMIT_HI: begin
        if (m_axis_tready) begin
          if (state_q == ST_EMIT_LO && mode_q) begin
            state_d = ST_EMIT_HI;
          end else if (final_q) begin
            state_d = ST_IDLE;
          end else if (pend_q) begin
            state_d = ST_PAD;
          end else begin
            buf_d   = '0;
            ptr_d   = '0;
            state_d = ST_FILL;
          end
        end
      end
      ST_PAD: begin
        buf_d   = ins_blk;
        final_d = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_EMIT_LO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tuser_q <= '0;
      mode_q  <= 1'b0;
      final_q <= 1'b0;
      pend_q  <= 1'b0;
      defer_q <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tuser_q <= tuser_d;
      mode_q  <= mode_d;
      final_q <= final_d;
      pend_q  <= pend_d;
      defer_q <= defer_d;
      init_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: table of messages checked against an
// independent padding model, plus stall and mid-emission reset sequences.
module tb_sha_padder;
  import sha_padder_pkg::*;

  logic         clk = 1'b0;
  logic         axis_resetn;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;

  sha_padder dut (
    .axis_aclk     (clk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] codec;
    int         len;
    int         exp_beats;
    int         hc_idx;
    logic [7:0] hc_val;
  } vec_t;

  vec_t         vecs [12];
  int           total = 0;
  int           bad   = 0;
  int           viol  = 0;
  logic [7:0]   got  [0:511];
  logic [7:0]   expb [0:511];
  int           got_beats, last_idx, tuser_bad;
  logic [127:0] cur_tu;

  // Input must never be accepted while a block is on the master side.
  always @(negedge clk) begin
    if (axis_resetn && m_axis_tvalid && s_axis_tready) viol++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic prep(input logic [3:0] codec, input int len);
    int bs, lb, tot;
    longint lbits;
    bs  = (codec == CODEC_SHA384 || codec == CODEC_SHA512) ? 128 : 64;
    lb  = (bs == 128) ? 16 : 8;
    tot = ((len + 1 + lb + bs - 1) / bs) * bs;
    for (int i = 0; i < 512; i++) begin
      got[i]  = 8'hEE;
      expb[i] = 8'h00;
    end
    for (int i = 0; i < len; i++) expb[i] = 8'h61 + 8'(i);
    expb[len] = 8'h80;
    lbits = longint'(len) * 8;
    for (int i = 0; i < 8; i++) expb[tot-1-i] = 8'(lbits >> (8*i));
    cur_tu    = {64'hDEAD_BEEF_0123_4567, 32'(len), 28'h0, codec};
    got_beats = 0;
    last_idx  = -1;
    tuser_bad = 0;
  endtask

  // Called on a negedge; returns on a negedge after the last beat is taken.
  task automatic send_msg(input logic [3:0] codec, input int len);
    int nb, cyc, idx;
    nb = (len == 0) ? 1 : (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int k = 0; k < 8; k++) begin
        idx = b*8 + k;
        if (idx < len) begin
          s_axis_tdata[8*k +: 8] = 8'h61 + 8'(idx);
          s_axis_tkeep[k] = 1'b1;
        end
      end
      s_axis_tuser  = {64'hDEAD_BEEF_0123_4567, 32'(len), 28'h0, codec};
      s_axis_tlast  = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      cyc = 0;
      while (!s_axis_tready && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      if (!s_axis_tready) begin
        total++; bad++;
        $display("FAIL send_timeout: beat %0d never accepted", b);
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic recv_msg();
    int cyc;
    cyc = 0;
    while (1) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (got_beats < 8)
          for (int k = 0; k < 64; k++) got[got_beats*64 + k] = m_axis_tdata[8*k +: 8];
        if (m_axis_tuser !== cur_tu) tuser_bad++;
        if (m_axis_tlast) begin
          last_idx = got_beats;
          got_beats++;
          @(negedge clk);
          break;
        end
        got_beats++;
      end
      if (cyc >= 600) begin
        total++; bad++;
        $display("FAIL recv_timeout: beats=%0d required tlast", got_beats);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic verify(input int tag, input int exp_beats);
    int fbad, first_bad;
    fbad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_beats*64; i++) begin
      if (got[i] !== expb[i]) begin
        fbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    chk($sformatf("v%0d beats", tag), got_beats, exp_beats);
    chk($sformatf("v%0d tlast_idx", tag), last_idx, exp_beats - 1);
    chk($sformatf("v%0d bad_bytes(first=%0d)", tag, first_bad), fbad, 0);
    chk($sformatf("v%0d tuser_bad", tag), tuser_bad, 0);
  endtask

  task automatic run_vec(input int i);
    prep(vecs[i].codec, vecs[i].len);
    fork
      send_msg(vecs[i].codec, vecs[i].len);
      recv_msg();
    join
    verify(i, vecs[i].exp_beats);
    chk($sformatf("v%0d byte%0d", i, vecs[i].hc_idx), got[vecs[i].hc_idx], vecs[i].hc_val);
  endtask

  initial begin
    int cyc, stable_bad;
    logic [511:0] snap_d;
    logic [127:0] snap_u;

    vecs[0]  = '{CODEC_SHA256,   3, 1,  63, 8'h18};  // "abc"
    vecs[1]  = '{CODEC_SHA512,   0, 2,   0, 8'h80};
    vecs[2]  = '{CODEC_SHA256,  56, 2, 126, 8'h01};
    vecs[3]  = '{CODEC_SHA384, 120, 4, 254, 8'h03};
    vecs[4]  = '{CODEC_SHA256,  55, 1,  63, 8'hB8};
    vecs[5]  = '{CODEC_SHA256,  64, 2,  64, 8'h80};
    vecs[6]  = '{CODEC_SHA512, 111, 2, 127, 8'h78};
    vecs[7]  = '{CODEC_SHA512, 112, 4, 112, 8'h80};
    vecs[8]  = '{CODEC_SHA1,    20, 1,  63, 8'hA0};
    vecs[9]  = '{4'hF,          70, 2, 126, 8'h02};
    vecs[10] = '{CODEC_SHA224,   0, 1,   0, 8'h80};
    vecs[11] = '{CODEC_SHA384, 128, 4, 128, 8'h80};

    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    axis_resetn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst m_tvalid", m_axis_tvalid, 0);
    chk("rst m_tlast", m_axis_tlast, 0);
    chk("rst m_tuser", m_axis_tuser, 0);
    chk("rst s_tready", s_axis_tready, 0);
    axis_resetn = 1'b1;
    #1 chk("release s_tready first cycle", s_axis_tready, 0);
    @(negedge clk);
    chk("release s_tready after", s_axis_tready, 1);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Master stall for 5 cycles while the single block is presented.
    prep(CODEC_SHA256, 16);
    m_axis_tready = 1'b0;
    stable_bad = 0;
    fork
      send_msg(CODEC_SHA256, 16);
      begin
        cyc = 0;
        while (!m_axis_tvalid && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        snap_d = m_axis_tdata;
        snap_u = m_axis_tuser;
        repeat (5) begin
          @(negedge clk);
          if (!m_axis_tvalid || m_axis_tdata !== snap_d || m_axis_tuser !== snap_u || s_axis_tready)
            stable_bad++;
        end
        m_axis_tready = 1'b1;
        recv_msg();
      end
    join
    chk("stall stable_bad", stable_bad, 0);
    verify(100, 1);

    // Reset while the upper half of a SHA-512 block is on the bus.
    m_axis_tready = 1'b0;
    fork
      send_msg(CODEC_SHA512, 10);
      begin
        cyc = 0;
        while (!m_axis_tvalid && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        chk("emit_hi tvalid", m_axis_tvalid, 1);
        chk("emit_hi tlast", m_axis_tlast, 1);
      end
    join
    axis_resetn = 1'b0;
    #1;
    chk("midrst m_tvalid", m_axis_tvalid, 0);
    chk("midrst m_tlast", m_axis_tlast, 0);
    chk("midrst m_tuser", m_axis_tuser, 0);
    chk("midrst s_tready", s_axis_tready, 0);
    @(negedge clk);
    axis_resetn = 1'b1;
    repeat (2) @(negedge clk);
    m_axis_tready = 1'b1;
    run_vec(0);

    chk("s_tready during emit", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
